instr_issue_unit: RTL and testbench

- Front end that drives the 5-bit OpFn into the control decoder and consumes the decoder's NIA result to sequence the program counter.
- Fetches instruction words from instruction memory with a req/ack handshake, latches each word, and splits it into opfn, register and immediate fields.
- Presents each instruction to the datapath/decoder with a valid/ready handshake, then computes the next PC.

---
 rtl/instr_issue_unit_if.sv | 40 ++++
 rtl/instr_issue_unit.sv | 103 ++++++++++
 tb/tb_instr_issue_unit.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_issue_unit_if.sv
// Bus bundle for instr_issue_unit: instruction-memory fetch port plus the
// issue port toward the datapath/decoder. The unit uses master, the environment uses slave.
interface instr_issue_unit_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               issue_valid;
  logic               issue_ready;
  logic [4:0]         opfn;
  logic [2:0]         rs;
  logic [2:0]         rt;
  logic [2:0]         rd;
  logic [7:0]         imm;
  logic               nia;
  logic [PC_W-1:0]    pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output issue_valid,
    input  issue_ready,
    output opfn, rs, rt, rd, imm,
    input  nia,
    output pc
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  issue_valid,
    output issue_ready,
    input  opfn, rs, rt, rd, imm,
    output nia,
    input  pc
  );
endinterface

// File: rtl/instr_issue_unit.sv
// Instruction fetch/issue front end: fetches words, splits fields, issues, sequences PC.
// Optional retire counter enabled by defining INSTR_ISSUE_RETIRE_CNT_EN.
module instr_issue_unit #(
  parameter int          PC_W     = 8,
  parameter int          INSTR_W  = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                halted,
`ifdef INSTR_ISSUE_RETIRE_CNT_EN
  output logic [15:0]         retire_cnt,
`endif
  instr_issue_unit_if.master  bus
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} state_t;

  state_t             state, state_nx;
  logic [PC_W-1:0]    pc_q, pc_nx;
  logic [INSTR_W-1:0] instr_q;
  logic               halted_q;
  logic               fetch_done;
  logic               illegal;
  logic               handshake;
  logic [PC_W-1:0]    jump_pc;

  assign illegal = (bus.imem_rdata[15:14] == 2'b11);

  // Jump target is instr[10:11-PC_W]; wider PCs get instr[10:0] zero-extended.
  generate
    if (PC_W <= 11) begin : g_jump_slice
      assign jump_pc = instr_q[10 -: PC_W];
    end else begin : g_jump_zext
      assign jump_pc = {{(PC_W-11){1'b0}}, instr_q[10:0]};
    end
  endgenerate

  always_comb begin
    state_nx        = state;
    pc_nx           = pc_q;
    fetch_done      = 1'b0;
    handshake       = 1'b0;
    bus.imem_req    = 1'b0;
    bus.issue_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = FETCH;
      end
      FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ack) begin
          fetch_done = 1'b1;
          state_nx   = illegal ? HALT : ISSUE;
        end
      end
      ISSUE: begin
        bus.issue_valid = 1'b1;
        if (bus.issue_ready) begin
          handshake = 1'b1;
          pc_nx     = bus.nia ? pc_q + PC_W'(1) : jump_pc;
          state_nx  = FETCH;
        end
      end
      HALT: ;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc_q     <= PC_W'(RESET_PC);
      instr_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      state <= state_nx;
      pc_q  <= pc_nx;
      if (fetch_done) begin
        instr_q <= bus.imem_rdata;
        if (illegal) halted_q <= 1'b1;
      end
    end
  end

`ifdef INSTR_ISSUE_RETIRE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         retire_cnt <= '0;
    else if (handshake) retire_cnt <= retire_cnt + 16'd1;
  end
`endif

  assign halted        = halted_q;
  assign bus.imem_addr = pc_q;
  assign bus.pc        = pc_q;
  assign bus.opfn      = instr_q[15:11];
  assign bus.rs        = instr_q[10:8];
  assign bus.rt        = instr_q[7:5];
  assign bus.rd        = instr_q[4:2];
  assign bus.imm       = {{3{instr_q[4]}}, instr_q[4:0]};

endmodule

// File: tb/tb_instr_issue_unit.sv
// Self-checking bench for instr_issue_unit: directed scenarios plus randomized
// memory/handshake traffic checked against a transaction-level model.
module tb_instr_issue_unit;
  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic halted;
`ifdef INSTR_ISSUE_RETIRE_CNT_EN
  logic [15:0] retire_cnt;
`endif

  instr_issue_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

  instr_issue_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .halted     (halted),
`ifdef INSTR_ISSUE_RETIRE_CNT_EN
    .retire_cnt (retire_cnt),
`endif
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Model: which transaction the unit should be in, what it should show.
  typedef enum {M_IDLE, M_FETCH, M_ISSUE, M_HALT} mph_t;
  mph_t         ph;
  logic [7:0]   exp_pc;
  logic [15:0]  exp_word;
  bit           exp_halt;
  int unsigned  exp_ret;
  logic [15:0]  mem [256];

  int errors = 0;
  int checks = 0;
  int ack_lat_sel = -1, ready_hold_sel = -1, nia_sel = -1;
  bit spurious_en = 1'b1;
  int wait_cnt = 0, lat = 0, hold = 0;
  int req_cycles = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input int sel);
    return (sel >= 0) ? sel : int'($urandom_range(0, 3));
  endfunction

  task automatic model_reset();
    ph = M_IDLE; exp_pc = '0; exp_word = '0; exp_halt = 1'b0; exp_ret = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0;
    bus.imem_ack = 1'b0; bus.issue_ready = 1'b0; bus.nia = 1'b0; bus.imem_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    chk("rst halted", 32'(halted), 32'd0);
    chk("rst opfn",   32'(bus.opfn), 32'd0);
    chk("rst rs_rt_rd", 32'({bus.rs, bus.rt, bus.rd}), 32'd0);
    chk("rst imm",    32'(bus.imm), 32'd0);
    chk("rst pc",     32'(bus.pc), 32'd0);
  endtask

  // Called at a negedge: compare outputs, choose inputs for the next posedge, advance model.
  task automatic step(input bit st);
    logic [15:0] w;
    chk("halted", 32'(halted), 32'(exp_halt));
`ifdef INSTR_ISSUE_RETIRE_CNT_EN
    chk("retire_cnt", 32'(retire_cnt), 32'(exp_ret[15:0]));
`endif
    case (ph)
      M_FETCH: begin
        chk("imem_req", 32'(bus.imem_req), 32'd1);
        chk("issue_valid", 32'(bus.issue_valid), 32'd0);
        chk("imem_addr", 32'(bus.imem_addr), 32'(exp_pc));
      end
      M_ISSUE: begin
        chk("imem_req", 32'(bus.imem_req), 32'd0);
        chk("issue_valid", 32'(bus.issue_valid), 32'd1);
        chk("pc", 32'(bus.pc), 32'(exp_pc));
        chk("opfn", 32'(bus.opfn), 32'(exp_word[15:11]));
        chk("rs", 32'(bus.rs), 32'(exp_word[10:8]));
        chk("rt", 32'(bus.rt), 32'(exp_word[7:5]));
        chk("rd", 32'(bus.rd), 32'(exp_word[4:2]));
        chk("imm", 32'(bus.imm), 32'({{3{exp_word[4]}}, exp_word[4:0]}));
      end
      default: begin
        chk("imem_req", 32'(bus.imem_req), 32'd0);
        chk("issue_valid", 32'(bus.issue_valid), 32'd0);
        chk("pc", 32'(bus.pc), 32'(exp_pc));
      end
    endcase

    start = st;
    bus.imem_ack    = spurious_en && ($urandom_range(0, 7) == 0);
    bus.imem_rdata  = 16'($urandom);
    bus.issue_ready = 1'($urandom);
    bus.nia         = (nia_sel >= 0) ? 1'(nia_sel) : 1'($urandom);
    case (ph)
      M_IDLE: if (st) begin ph = M_FETCH; wait_cnt = 0; lat = pick(ack_lat_sel); end
      M_FETCH: begin
        req_cycles++;
        if (wait_cnt >= lat) begin
          w = mem[exp_pc];
          bus.imem_ack = 1'b1; bus.imem_rdata = w; exp_word = w;
          if (w[15:13] >= 3'b110) begin ph = M_HALT; exp_halt = 1'b1; end
          else begin ph = M_ISSUE; wait_cnt = 0; hold = pick(ready_hold_sel); end
        end else begin
          bus.imem_ack = 1'b0;
          wait_cnt++;
        end
      end
      M_ISSUE: begin
        if (wait_cnt >= hold) begin
          bus.issue_ready = 1'b1;
          exp_pc  = bus.nia ? exp_pc + 8'd1 : exp_word[10:3];
          exp_ret = exp_ret + 1;
          ph = M_FETCH; wait_cnt = 0; lat = pick(ack_lat_sel);
        end else begin
          bus.issue_ready = 1'b0;
          wait_cnt++;
        end
      end
      default: ;
    endcase
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h00] = 16'h0000;
    mem[8'h01] = 16'hA0A8;
    mem[8'h15] = 16'h1234;
    spurious_en = 1'b1;
    do_reset();
    chk("idle req", 32'(bus.imem_req), 32'd0);
    chk("idle valid", 32'(bus.issue_valid), 32'd0);

    // Fetch of ADD at 0 with ack two cycles after req, then sequential issue.
    ack_lat_sel = 2; ready_hold_sel = 0; nia_sel = 1;
    step(1'b1);
    req_cycles = 0;
    repeat (3) step(1'b0);
    chk("add req cycles", 32'(req_cycles), 32'd3);
    chk("add valid", 32'(bus.issue_valid), 32'd1);
    chk("add opfn", 32'(bus.opfn), 32'd0);
    ack_lat_sel = 0;
    step(1'b0);
    chk("add next addr", 32'(bus.imem_addr), 32'h01);

    // Jump word A0A8.
    nia_sel = 0;
    step(1'b0);
    chk("jump opfn", 32'(bus.opfn), 32'b10100);
    step(1'b0);
    chk("jump addr", 32'(bus.imem_addr), 32'h15);

    // Ready held low for five cycles.
    nia_sel = 1; ready_hold_sel = 5;
    step(1'b0);
    for (int k = 0; k < 5; k++) begin
      chk("stall valid", 32'(bus.issue_valid), 32'd1);
      chk("stall req", 32'(bus.imem_req), 32'd0);
      chk("stall pc", 32'(bus.pc), 32'h15);
      chk("stall opfn", 32'(bus.opfn), 32'h02);
      chk("stall rs", 32'(bus.rs), 32'h2);
      step(1'b0);
    end
    ack_lat_sel = 3; ready_hold_sel = 0;
    step(1'b0);
    chk("stall next addr", 32'(bus.imem_addr), 32'h16);

    // Asynchronous reset while req is high.
    chk("pre-rst req", 32'(bus.imem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async req drop", 32'(bus.imem_req), 32'd0);
    chk("async valid", 32'(bus.issue_valid), 32'd0);
    chk("async pc", 32'(bus.pc), 32'd0);
`ifdef INSTR_ISSUE_RETIRE_CNT_EN
    chk("async retire_cnt", 32'(retire_cnt), 32'd0);
`endif
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    repeat (3) step(1'b0);

    // PC wrap at FF and sign-extended imm.
    mem[8'h00] = 16'h07F8;
    mem[8'hFF] = 16'h281F;
    ack_lat_sel = 0; ready_hold_sel = 0; nia_sel = 0;
    step(1'b1);
    step(1'b0);
    step(1'b0);
    chk("wrap addr ff", 32'(bus.imem_addr), 32'hFF);
    nia_sel = 1;
    step(1'b0);
    chk("imm ff", 32'(bus.imm), 32'hFF);
    chk("pc ff", 32'(bus.pc), 32'hFF);
    step(1'b0);
    chk("wrap addr 00", 32'(bus.imem_addr), 32'h00);

    // Illegal opcode halts; start pulses ignored.
    mem[8'h00] = 16'hC000;
    step(1'b0);
    chk("halt flag", 32'(halted), 32'd1);
    repeat (4) step(1'b1);
    chk("halt pc", 32'(bus.pc), 32'h00);
    chk("halt valid", 32'(bus.issue_valid), 32'd0);
    do_reset();

    // Randomized traffic.
    ack_lat_sel = -1; ready_hold_sel = -1; nia_sel = -1; spurious_en = 1'b1;
    for (int e = 0; e < 12; e++) begin
      for (int i = 0; i < 256; i++) begin
        mem[i] = 16'($urandom);
        if (mem[i][15:14] == 2'b11 && $urandom_range(0, 15) != 0) mem[i][15] = 1'b0;
      end
      do_reset();
      repeat (300) step($urandom_range(0, 3) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
